// File: rtl/dcache_ld_arbiter.sv
// ---------------------------------------------------------------------------
// dcache_ld_arbiter
//
// Shares the single D-cache load port between NUM_REQ load requesters with
// round-robin arbitration. Every accepted load pushes the requester index into
// an in-order ID FIFO. D$ responses are returned in order, so the FIFO head
// tells us which requester owns the current response. A flush marks every
// in-flight entry as killed. Responses for killed entries are accepted from
// the D$ and dropped.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   flush_i                 kill all in-flight loads, block new grants
//   req_valid_i/ready_o     per-requester load request handshake
//   req_addr_i, req_op_i    per-requester address and load op
//   rsp_valid_o/ready_i     per-requester response handshake
//   rsp_data_o, rsp_err_o   shared response payload (qualified by rsp_valid_o)
//   ld_req_*                D$ load request channel
//   ld_rsp_*                D$ load response channel
// ---------------------------------------------------------------------------
package decode_pkg;
    typedef enum logic [3:0] {
        LSU_LB  = 4'd0,
        LSU_LH  = 4'd1,
        LSU_LW  = 4'd2,
        LSU_LBU = 4'd3,
        LSU_LHU = 4'd4,
        LSU_SB  = 4'd8,
        LSU_SH  = 4'd9,
        LSU_SW  = 4'd10
    } lsu_op_e;
endpackage

module dcache_ld_arbiter
    import decode_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int PLEN            = 32,
    parameter int XLEN            = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ID_W            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ-1:0][PLEN-1:0]   req_addr_i,
    input  lsu_op_e [NUM_REQ-1:0]          req_op_i,
    output logic [NUM_REQ-1:0]             rsp_valid_o,
    input  logic [NUM_REQ-1:0]             rsp_ready_i,
    output logic [XLEN-1:0]                rsp_data_o,
    output logic                           rsp_err_o,
    output logic                           ld_req_valid_o,
    input  logic                           ld_req_ready_i,
    output logic [PLEN-1:0]                ld_req_addr_o,
    output lsu_op_e                        ld_req_op_o,
    input  logic                           ld_rsp_valid_i,
    output logic                           ld_rsp_ready_o,
    input  logic [XLEN-1:0]                ld_rsp_data_i,
    input  logic                           ld_rsp_err_i
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]           count_reg, count_next;
    logic [PTR_W-1:0]           head_reg, head_next;
    logic [PTR_W-1:0]           tail_reg, tail_next;
    logic [ID_W-1:0]            rr_ptr_reg, rr_ptr_next;
    logic                       lock_reg, lock_next;
    logic [ID_W-1:0]            lock_id_reg, lock_id_next;
    logic [ID_W-1:0]            id_mem_reg [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] killed_reg, killed_next;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [ID_W-1:0] winner;
    logic            found;
    logic            full;
    logic            empty;
    logic            grant_valid;
    logic            accept;

    // While a request is stalled by the D$ the grant is pinned to the same
    // requester so that addr/op presented to the D$ cannot change under it.
    always_comb begin
        int idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        if (lock_reg) begin
            winner = lock_id_reg;
            found  = req_valid_i[lock_id_reg];
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                idx = (int'(rr_ptr_reg) + i) % NUM_REQ;
                if (!found && req_valid_i[idx]) begin
                    found  = 1'b1;
                    winner = ID_W'(idx);
                end
            end
        end
    end

    assign full  = (count_reg == CNT_W'(MAX_OUTSTANDING));
    assign empty = (count_reg == '0);

    // Full blocks the grant even if a response pops this cycle: no bypass.
    assign grant_valid = found && !full && !flush_i && !rst_i;
    assign accept      = grant_valid && ld_req_ready_i;

    assign ld_req_valid_o = grant_valid;
    assign ld_req_addr_o  = rst_i ? '0 : req_addr_i[winner];
    assign ld_req_op_o    = rst_i ? LSU_LB : req_op_i[winner];

    always_comb begin
        req_ready_o = '0;
        if (accept) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    logic [ID_W-1:0] head_id;
    logic            head_killed;
    logic            pop;

    assign head_id     = id_mem_reg[head_reg];
    assign head_killed = killed_reg[head_reg];

    // Killed heads are drained unconditionally; an empty FIFO refuses the D$.
    always_comb begin
        rsp_valid_o    = '0;
        ld_rsp_ready_o = 1'b0;
        if (!rst_i && !empty) begin
            if (head_killed) begin
                ld_rsp_ready_o = 1'b1;
            end else begin
                rsp_valid_o[head_id] = ld_rsp_valid_i;
                ld_rsp_ready_o       = rsp_ready_i[head_id];
            end
        end
    end

    assign rsp_data_o = rst_i ? '0 : ld_rsp_data_i;
    assign rsp_err_o  = rst_i ? 1'b0 : ld_rsp_err_i;
    assign pop        = ld_rsp_valid_i && ld_rsp_ready_o;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        count_next   = count_reg;
        head_next    = head_reg;
        tail_next    = tail_reg;
        rr_ptr_next  = rr_ptr_reg;
        lock_next    = lock_reg;
        lock_id_next = lock_id_reg;

        if (accept && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!accept && pop) begin
            count_next = count_reg - CNT_W'(1);
        end

        if (accept) begin
            tail_next   = (tail_reg == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : tail_reg + PTR_W'(1);
            rr_ptr_next = (int'(winner) == NUM_REQ - 1) ? '0 : winner + ID_W'(1);
        end
        if (pop) begin
            head_next = (head_reg == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : head_reg + PTR_W'(1);
        end

        if (flush_i || accept) begin
            lock_next = 1'b0;
        end else if (grant_valid && !ld_req_ready_i) begin
            lock_next    = 1'b1;
            lock_id_next = winner;
        end
    end

    // Per-entry kill flags: a flush kills everything in flight; a fresh push
    // clears the flag of the slot it lands in (never both in one cycle).
    for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_killed
        assign killed_next[gi] = flush_i ? 1'b1
                               : (accept && tail_reg == PTR_W'(gi)) ? 1'b0
                               : killed_reg[gi];
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_reg   <= '0;
            head_reg    <= '0;
            tail_reg    <= '0;
            rr_ptr_reg  <= '0;
            lock_reg    <= 1'b0;
            lock_id_reg <= '0;
            killed_reg  <= '0;
        end else begin
            count_reg   <= count_next;
            head_reg    <= head_next;
            tail_reg    <= tail_next;
            rr_ptr_reg  <= rr_ptr_next;
            lock_reg    <= lock_next;
            lock_id_reg <= lock_id_next;
            killed_reg  <= killed_next;
        end
    end

    // ID storage needs no reset: entries are only read while count is nonzero.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            id_mem_reg[tail_reg] <= winner;
        end
    end

`ifndef SYNTHESIS
    // A D$ response with nothing outstanding means the D$ and this block
    // have lost track of each other.
    rsp_on_empty_fifo : assert property (@(posedge clk_i) disable iff (rst_i)
        !(ld_rsp_valid_i && empty));
`endif

endmodule

// File: tb/tb_dcache_ld_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dcache_ld_arbiter
//
// Directed cycle table for the key scenarios (reset, single load, round-robin,
// full FIFO without bypass, flush drain, grant lock, stalled error response),
// followed by randomized traffic against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_dcache_ld_arbiter;
    import decode_pkg::*;

    localparam int N    = 2;
    localparam int MAXO = 4;

    logic                 clk;
    logic                 rst;
    logic                 flush;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    logic [N-1:0][31:0]   req_addr;
    lsu_op_e [N-1:0]      req_op;
    logic [N-1:0]         rsp_valid;
    logic [N-1:0]         rsp_ready;
    logic [31:0]          rsp_data;
    logic                 rsp_err;
    logic                 ld_req_valid;
    logic                 ld_req_ready;
    logic [31:0]          ld_req_addr;
    lsu_op_e              ld_req_op;
    logic                 ld_rsp_valid;
    logic                 ld_rsp_ready;
    logic [31:0]          ld_rsp_data;
    logic                 ld_rsp_err;

    dcache_ld_arbiter #(
        .NUM_REQ(N), .PLEN(32), .XLEN(32), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_op_i(req_op),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
        .ld_req_valid_o(ld_req_valid), .ld_req_ready_i(ld_req_ready),
        .ld_req_addr_o(ld_req_addr), .ld_req_op_o(ld_req_op),
        .ld_rsp_valid_i(ld_rsp_valid), .ld_rsp_ready_o(ld_rsp_ready),
        .ld_rsp_data_i(ld_rsp_data), .ld_rsp_err_i(ld_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed table: one row per cycle, outputs checked before the edge
    // ------------------------------------------------------------------
    typedef struct {
        logic        rst;
        logic        flush;
        logic [1:0]  rv;        // req_valid
        logic        rdy;       // ld_req_ready
        logic        dv;        // ld_rsp_valid
        logic        derr;      // ld_rsp_err
        logic [1:0]  rr;        // rsp_ready
        logic [1:0]  e_req_ready;
        logic        e_lv;
        logic [31:0] e_addr;
        logic [1:0]  e_rsp_valid;
        logic        e_ldrr;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl [NV];

    initial begin
        // rst flush rv    rdy dv derr rr   | req_rdy lv addr    rsp_v ldrr
        tbl[0]  = '{1, 0, 2'b11, 1, 0, 0, 2'b11, 2'b00, 0, 32'h0,   2'b00, 0}; // reset: outputs idle
        tbl[1]  = '{0, 0, 2'b01, 1, 0, 0, 2'b11, 2'b01, 1, 32'h100, 2'b00, 0}; // single load req0
        tbl[2]  = '{0, 0, 2'b00, 1, 1, 0, 2'b11, 2'b00, 0, 32'h0,   2'b01, 1}; // response -> req0
        tbl[3]  = '{1, 0, 2'b11, 1, 0, 0, 2'b11, 2'b00, 0, 32'h0,   2'b00, 0}; // reset, rr back to 0
        tbl[4]  = '{0, 0, 2'b11, 1, 0, 0, 2'b11, 2'b01, 1, 32'h100, 2'b00, 0}; // rr: 0
        tbl[5]  = '{0, 0, 2'b11, 1, 0, 0, 2'b11, 2'b10, 1, 32'h40,  2'b00, 1}; // rr: 1
        tbl[6]  = '{0, 0, 2'b11, 1, 0, 0, 2'b11, 2'b01, 1, 32'h100, 2'b00, 1}; // rr: 0
        tbl[7]  = '{0, 0, 2'b11, 1, 0, 0, 2'b11, 2'b10, 1, 32'h40,  2'b00, 1}; // rr: 1, now full
        tbl[8]  = '{0, 0, 2'b11, 1, 1, 0, 2'b11, 2'b00, 0, 32'h0,   2'b01, 1}; // full + pop: no grant
        tbl[9]  = '{0, 0, 2'b11, 1, 0, 0, 2'b11, 2'b01, 1, 32'h100, 2'b00, 1}; // granted next cycle
        tbl[10] = '{0, 1, 2'b11, 1, 1, 0, 2'b11, 2'b00, 0, 32'h0,   2'b10, 1}; // flush: pop still delivered
        tbl[11] = '{0, 0, 2'b00, 1, 1, 0, 2'b00, 2'b00, 0, 32'h0,   2'b00, 1}; // killed drain 1
        tbl[12] = '{0, 0, 2'b00, 1, 1, 0, 2'b00, 2'b00, 0, 32'h0,   2'b00, 1}; // killed drain 2
        tbl[13] = '{0, 0, 2'b00, 1, 1, 0, 2'b00, 2'b00, 0, 32'h0,   2'b00, 1}; // killed drain 3
        tbl[14] = '{0, 0, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0, 32'h0,   2'b00, 0}; // FIFO empty
        tbl[15] = '{1, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 32'h0,   2'b00, 0}; // reset
        tbl[16] = '{0, 0, 2'b10, 0, 0, 0, 2'b11, 2'b00, 1, 32'h40,  2'b00, 0}; // req1 stalled -> lock
        tbl[17] = '{0, 0, 2'b11, 0, 0, 0, 2'b11, 2'b00, 1, 32'h40,  2'b00, 0}; // req0 cannot steal
        tbl[18] = '{0, 0, 2'b11, 0, 0, 0, 2'b11, 2'b00, 1, 32'h40,  2'b00, 0}; // still locked
        tbl[19] = '{0, 0, 2'b11, 1, 0, 0, 2'b11, 2'b10, 1, 32'h40,  2'b00, 0}; // req1 accepted
        tbl[20] = '{0, 0, 2'b01, 0, 1, 1, 2'b01, 2'b00, 1, 32'h100, 2'b10, 0}; // req1 rsp stalled
        tbl[21] = '{0, 0, 2'b01, 0, 1, 1, 2'b01, 2'b00, 1, 32'h100, 2'b10, 0}; // still stalled
        tbl[22] = '{0, 0, 2'b01, 0, 1, 1, 2'b10, 2'b00, 1, 32'h100, 2'b10, 1}; // handshake, err=1
        tbl[23] = '{0, 0, 2'b01, 1, 0, 0, 2'b11, 2'b01, 1, 32'h100, 2'b00, 0}; // popped: FIFO empty
    end

    // ------------------------------------------------------------------
    // Reference model state for the random phase
    // ------------------------------------------------------------------
    int          mq_id [$];      // requester of each outstanding load, oldest first
    bit          mq_k  [$];      // killed flag per outstanding load
    logic [32:0] dq    [$];      // D$ side: {err, data} of each pending response
    int          m_rr;
    bit          m_lock;
    int          m_lock_id;
    bit          hv    [N];
    logic [31:0] haddr [N];
    lsu_op_e     hop   [N];
    bit          dvalid;

    initial begin
        rst          = 1'b1;
        flush        = 1'b0;
        req_valid    = '0;
        req_addr     = '0;
        req_op       = {LSU_LW, LSU_LW};
        rsp_ready    = '0;
        ld_req_ready = 1'b0;
        ld_rsp_valid = 1'b0;
        ld_rsp_data  = '0;
        ld_rsp_err   = 1'b0;
        @(posedge clk);

        // ---------------- directed table ----------------
        for (int v = 0; v < NV; v++) begin
            @(negedge clk);
            rst          = tbl[v].rst;
            flush        = tbl[v].flush;
            req_valid    = tbl[v].rv;
            req_addr[0]  = 32'h100;
            req_addr[1]  = 32'h40;
            req_op[0]    = LSU_LW;
            req_op[1]    = LSU_LW;
            ld_req_ready = tbl[v].rdy;
            ld_rsp_valid = tbl[v].dv;
            ld_rsp_data  = 32'hDEADBEEF;
            ld_rsp_err   = tbl[v].derr;
            rsp_ready    = tbl[v].rr;
            #1;
            chk($sformatf("row%0d req_ready", v), 32'(req_ready), 32'(tbl[v].e_req_ready));
            chk($sformatf("row%0d ld_req_valid", v), 32'(ld_req_valid), 32'(tbl[v].e_lv));
            if (tbl[v].e_lv) begin
                chk($sformatf("row%0d ld_req_addr", v), ld_req_addr, tbl[v].e_addr);
                chk($sformatf("row%0d ld_req_op", v), 32'(ld_req_op), 32'(LSU_LW));
            end
            chk($sformatf("row%0d rsp_valid", v), 32'(rsp_valid), 32'(tbl[v].e_rsp_valid));
            chk($sformatf("row%0d ld_rsp_ready", v), 32'(ld_rsp_ready), 32'(tbl[v].e_ldrr));
            if (tbl[v].e_rsp_valid != 2'b00) begin
                chk($sformatf("row%0d rsp_data", v), rsp_data, 32'hDEADBEEF);
                chk($sformatf("row%0d rsp_err", v), 32'(rsp_err), 32'(tbl[v].derr));
            end
        end

        // ---------------- random phase ----------------
        // Start from reset so the model and DUT agree.
        @(negedge clk);
        rst          = 1'b1;
        flush        = 1'b0;
        req_valid    = '0;
        ld_rsp_valid = 1'b0;
        mq_id.delete(); mq_k.delete(); dq.delete();
        m_rr = 0; m_lock = 0; m_lock_id = 0; dvalid = 0;
        for (int r = 0; r < N; r++) begin
            hv[r] = 0; haddr[r] = '0; hop[r] = LSU_LB;
        end

        for (int cyc = 0; cyc < 3000; cyc++) begin
            int          w;
            bit          r_rst, r_flush, rdy;
            bit          e_lv, e_ldrr;
            logic [1:0]  e_rr, e_rv, rr_in;

            @(negedge clk);
            r_rst   = (cyc == 0) || ($urandom_range(0, 199) == 0);
            r_flush = ($urandom_range(0, 24) == 0);
            rdy     = ($urandom_range(0, 3) != 0);
            rr_in   = 2'($urandom);

            // Requesters raise a new load only when not holding one.
            for (int r = 0; r < N; r++) begin
                if (!hv[r] && $urandom_range(0, 1) == 1) begin
                    hv[r]    = 1;
                    haddr[r] = $urandom;
                    hop[r]   = lsu_op_e'($urandom_range(0, 4));
                end
            end
            // D$ raises a response for the oldest pending load and holds it.
            if (!dvalid && dq.size() > 0 && $urandom_range(0, 2) != 0) dvalid = 1;

            rst          = r_rst;
            flush        = r_flush;
            for (int r = 0; r < N; r++) begin
                req_valid[r] = hv[r];
                req_addr[r]  = haddr[r];
                req_op[r]    = hop[r];
            end
            ld_req_ready = rdy;
            rsp_ready    = rr_in;
            ld_rsp_valid = dvalid;
            ld_rsp_data  = dvalid ? dq[0][31:0] : 32'h0;
            ld_rsp_err   = dvalid ? dq[0][32] : 1'b0;
            #1;

            // Expected outputs from the model.
            w = -1;
            if (m_lock) w = m_lock_id;
            else begin
                for (int i = 0; i < N; i++) begin
                    int idx;
                    idx = (m_rr + i) % N;
                    if (w < 0 && hv[idx]) w = idx;
                end
            end
            e_lv = !r_rst && (w >= 0) && (mq_id.size() < MAXO) && !r_flush;
            e_rr = '0;
            if (e_lv && rdy) e_rr[w] = 1'b1;
            e_rv   = '0;
            e_ldrr = 0;
            if (!r_rst && mq_id.size() > 0) begin
                if (mq_k[0]) e_ldrr = 1;
                else begin
                    e_rv[mq_id[0]] = dvalid;
                    e_ldrr         = rr_in[mq_id[0]];
                end
            end

            chk($sformatf("rnd%0d req_ready", cyc), 32'(req_ready), 32'(e_rr));
            chk($sformatf("rnd%0d ld_req_valid", cyc), 32'(ld_req_valid), 32'(e_lv));
            if (e_lv) begin
                chk($sformatf("rnd%0d ld_req_addr", cyc), ld_req_addr, haddr[w]);
                chk($sformatf("rnd%0d ld_req_op", cyc), 32'(ld_req_op), 32'(hop[w]));
            end
            chk($sformatf("rnd%0d rsp_valid", cyc), 32'(rsp_valid), 32'(e_rv));
            chk($sformatf("rnd%0d ld_rsp_ready", cyc), 32'(ld_rsp_ready), 32'(e_ldrr));
            if (e_rv != 2'b00) begin
                chk($sformatf("rnd%0d rsp_data", cyc), rsp_data, dq[0][31:0]);
                chk($sformatf("rnd%0d rsp_err", cyc), 32'(rsp_err), 32'(dq[0][32]));
            end

            // Advance the model across the coming clock edge.
            if (r_rst) begin
                mq_id.delete(); mq_k.delete(); dq.delete();
                m_rr = 0; m_lock = 0; dvalid = 0;
            end else begin
                if (dvalid && e_ldrr) begin
                    void'(mq_id.pop_front());
                    void'(mq_k.pop_front());
                    void'(dq.pop_front());
                    dvalid = 0;
                end
                if (r_flush) begin
                    foreach (mq_k[k]) mq_k[k] = 1;
                    for (int r = 0; r < N; r++) hv[r] = 0;  // requesters withdraw
                    m_lock = 0;
                end
                if (e_lv && rdy) begin
                    mq_id.push_back(w);
                    mq_k.push_back(0);
                    dq.push_back({1'($urandom), 32'($urandom)});
                    hv[w]  = 0;
                    m_rr   = (w + 1) % N;
                    m_lock = 0;
                end else if (e_lv && !rdy) begin
                    m_lock    = 1;
                    m_lock_id = w;
                end
            end
        end

        @(negedge clk);
        rst = 1'b1;
        ld_rsp_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
